// File: rtl/vga_disp_ctrl_pkg.sv
// Shared timing constants, RGB565 colours, state encoding and stage payload for the VGA display path.
package vga_disp_ctrl_pkg;

    localparam int unsigned H_CNT_W = 11;
    localparam int unsigned V_CNT_W = 10;
    localparam int unsigned PIX_W   = 16;

    // 1024x768@60 raster, 65 MHz pixel clock
    localparam int unsigned VGA_H_ACT  = 1024;
    localparam int unsigned VGA_H_FP   = 24;
    localparam int unsigned VGA_H_SYNC = 136;
    localparam int unsigned VGA_H_BP   = 160;
    localparam int unsigned VGA_V_ACT  = 768;
    localparam int unsigned VGA_V_FP   = 3;
    localparam int unsigned VGA_V_SYNC = 6;
    localparam int unsigned VGA_V_BP   = 29;

    localparam int unsigned VGA_IMG_X0 = 192;
    localparam int unsigned VGA_IMG_Y0 = 144;
    localparam int unsigned VGA_IMG_W  = 640;
    localparam int unsigned VGA_IMG_H  = 480;

    localparam logic [PIX_W-1:0] RGB_BLACK   = 16'h0000;
    localparam logic [PIX_W-1:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [PIX_W-1:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [PIX_W-1:0] RGB_CYAN    = 16'h07FF;
    localparam logic [PIX_W-1:0] RGB_GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [PIX_W-1:0] RGB_RED     = 16'hF800;
    localparam logic [PIX_W-1:0] RGB_BLUE    = 16'h001F;

    typedef enum logic {
        S_WAIT   = 1'b0,
        S_ACTIVE = 1'b1
    } disp_state_e;

    // Stage-0 decode carried through the read-latency alignment pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic win;
        logic act;
        logic fs;
    } vga_stage_t;

    // Colour bar palette, left to right
    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        logic [PIX_W-1:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and stage-0 decode (sync, active, image window, frame markers).
module vga_timing_gen
    import vga_disp_ctrl_pkg::*;
#(
    parameter int unsigned H_ACT  = VGA_H_ACT,
    parameter int unsigned H_FP   = VGA_H_FP,
    parameter int unsigned H_SYNC = VGA_H_SYNC,
    parameter int unsigned H_BP   = VGA_H_BP,
    parameter int unsigned V_ACT  = VGA_V_ACT,
    parameter int unsigned V_FP   = VGA_V_FP,
    parameter int unsigned V_SYNC = VGA_V_SYNC,
    parameter int unsigned V_BP   = VGA_V_BP,
    parameter int unsigned IMG_X0 = VGA_IMG_X0,
    parameter int unsigned IMG_Y0 = VGA_IMG_Y0,
    parameter int unsigned IMG_W  = VGA_IMG_W,
    parameter int unsigned IMG_H  = VGA_IMG_H
) (
    input  logic               clk_65m,
    input  logic               rst_n,
    output logic               hs0_c,
    output logic               vs0_c,
    output logic               de0_c,
    output logic               win0_c,
    output logic               fs0_c,
    output logic               frame_end_c,
    output logic [H_CNT_W-1:0] win_x_c
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned H_ACT0  = H_SYNC + H_BP;
    localparam int unsigned V_ACT0  = V_SYNC + V_BP;

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic [H_CNT_W-1:0] x_c;
    logic [V_CNT_W-1:0] y_c;
    logic               h_last_c;
    logic               v_last_c;
    logic               de_h_c;
    logic               de_v_c;
    logic               win_h_c;
    logic               win_v_c;

    assign h_last_c = (h_cnt == H_CNT_W'(H_TOTAL - 1));
    assign v_last_c = (v_cnt == V_CNT_W'(V_TOTAL - 1));

    // Line order: sync, back porch, active, front porch
    always_ff @(posedge clk_65m or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last_c) begin
            h_cnt <= '0;
            v_cnt <= v_last_c ? '0 : v_cnt + V_CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + H_CNT_W'(1);
        end
    end

    // Active-region coordinates; only meaningful while de is high
    assign x_c = h_cnt - H_CNT_W'(H_ACT0);
    assign y_c = v_cnt - V_CNT_W'(V_ACT0);

    assign de_h_c  = (h_cnt >= H_CNT_W'(H_ACT0)) && (h_cnt < H_CNT_W'(H_ACT0 + H_ACT));
    assign de_v_c  = (v_cnt >= V_CNT_W'(V_ACT0)) && (v_cnt < V_CNT_W'(V_ACT0 + V_ACT));
    assign win_h_c = (x_c >= H_CNT_W'(IMG_X0)) && (x_c < H_CNT_W'(IMG_X0 + IMG_W));
    assign win_v_c = (y_c >= V_CNT_W'(IMG_Y0)) && (y_c < V_CNT_W'(IMG_Y0 + IMG_H));

    assign hs0_c       = (h_cnt < H_CNT_W'(H_SYNC));
    assign vs0_c       = (v_cnt < V_CNT_W'(V_SYNC));
    assign de0_c       = de_h_c && de_v_c;
    assign win0_c      = de0_c && win_h_c && win_v_c;
    assign fs0_c       = (h_cnt == '0) && (v_cnt == '0);
    assign frame_end_c = h_last_c && v_last_c;
    assign win_x_c     = x_c - H_CNT_W'(IMG_X0);

endmodule

// File: rtl/vga_disp_ctrl.sv
// VGA display timing and frame-buffer pixel fetch with windowed image placement.
// Optional colour-bar test pattern when VGA_COLORBAR_EN is defined.
module vga_disp_ctrl
    import vga_disp_ctrl_pkg::*;
#(
    parameter int unsigned      H_ACT    = VGA_H_ACT,
    parameter int unsigned      H_FP     = VGA_H_FP,
    parameter int unsigned      H_SYNC   = VGA_H_SYNC,
    parameter int unsigned      H_BP     = VGA_H_BP,
    parameter int unsigned      V_ACT    = VGA_V_ACT,
    parameter int unsigned      V_FP     = VGA_V_FP,
    parameter int unsigned      V_SYNC   = VGA_V_SYNC,
    parameter int unsigned      V_BP     = VGA_V_BP,
    parameter int unsigned      IMG_X0   = VGA_IMG_X0,
    parameter int unsigned      IMG_Y0   = VGA_IMG_Y0,
    parameter int unsigned      IMG_W    = VGA_IMG_W,
    parameter int unsigned      IMG_H    = VGA_IMG_H,
    parameter int unsigned      RD_LAT   = 1,
    parameter logic [PIX_W-1:0] BG_COLOR = RGB_BLACK,
    parameter logic [PIX_W-1:0] UF_COLOR = RGB_RED
) (
    input  logic             clk_65m,
    input  logic             rst_n,
    input  logic             disp_en,
    input  logic             colorbar_sel,
    output logic             vga_rd_req,
    input  logic [PIX_W-1:0] vga_din,
    input  logic             vga_din_vld,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_de,
    output logic [PIX_W-1:0] vga_rgb,
    output logic             frame_start,
    output logic             underflow
);

    logic               hs0_c;
    logic               vs0_c;
    logic               de0_c;
    logic               win0_c;
    logic               fs0_c;
    logic               frame_end_c;
    logic [H_CNT_W-1:0] win_x_c;
    disp_state_e        state;
    vga_stage_t         s0_c;
    vga_stage_t         st_c;
    vga_stage_t         dly [RD_LAT];
    logic [PIX_W-1:0]   rgb_c;
    logic               uf_c;

    vga_timing_gen #(
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .IMG_X0 (IMG_X0),
        .IMG_Y0 (IMG_Y0),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) u_timing (
        .clk_65m     (clk_65m),
        .rst_n       (rst_n),
        .hs0_c       (hs0_c),
        .vs0_c       (vs0_c),
        .de0_c       (de0_c),
        .win0_c      (win0_c),
        .fs0_c       (fs0_c),
        .frame_end_c (frame_end_c),
        .win_x_c     (win_x_c)
    );

    // disp_en only takes effect on the last pixel of a frame, so fetch covers whole frames
    always_ff @(posedge clk_65m or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
        end else if (frame_end_c) begin
            case (state)
                S_WAIT:   state <= disp_en ? S_ACTIVE : S_WAIT;
                S_ACTIVE: state <= disp_en ? S_ACTIVE : S_WAIT;
                default:  state <= S_WAIT;
            endcase
        end
    end

    // Request issued in the stage-0 cycle so data lands RD_LAT cycles later
    assign vga_rd_req = (state == S_ACTIVE) && win0_c;

    always_comb begin
        s0_c     = '0;
        s0_c.hs  = hs0_c;
        s0_c.vs  = vs0_c;
        s0_c.de  = de0_c;
        s0_c.win = win0_c;
        s0_c.act = (state == S_ACTIVE);
        s0_c.fs  = fs0_c;
    end

    always_ff @(posedge clk_65m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) dly[i] <= '0;
        end else begin
            dly[0] <= s0_c;
            for (int i = 1; i < int'(RD_LAT); i++) dly[i] <= dly[i-1];
        end
    end

    assign st_c = dly[RD_LAT-1];

`ifdef VGA_COLORBAR_EN
    logic [2:0] bar0_c;
    logic [2:0] bar_dly [RD_LAT];

    assign bar0_c = 3'(win_x_c / H_CNT_W'(IMG_W / 8));

    always_ff @(posedge clk_65m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) bar_dly[i] <= '0;
        end else begin
            bar_dly[0] <= bar0_c;
            for (int i = 1; i < int'(RD_LAT); i++) bar_dly[i] <= bar_dly[i-1];
        end
    end
`else
    logic unused_c;
    assign unused_c = ^{colorbar_sel, win_x_c};
`endif

    // Output pixel select; underflow only when a fetched pixel is missing
    always_comb begin
        rgb_c = '0;
        uf_c  = 1'b0;
        if (!st_c.de) begin
            rgb_c = '0;
        end else if (!st_c.win || !st_c.act) begin
            rgb_c = BG_COLOR;
`ifdef VGA_COLORBAR_EN
        end else if (colorbar_sel) begin
            rgb_c = bar_color(bar_dly[RD_LAT-1]);
`endif
        end else if (vga_din_vld) begin
            rgb_c = vga_din;
        end else begin
            rgb_c = UF_COLOR;
            uf_c  = 1'b1;
        end
    end

    always_ff @(posedge clk_65m or negedge rst_n) begin
        if (!rst_n) begin
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_de      <= 1'b0;
            vga_rgb     <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            vga_hsync   <= ~st_c.hs;
            vga_vsync   <= ~st_c.vs;
            vga_de      <= st_c.de;
            vga_rgb     <= rgb_c;
            frame_start <= st_c.fs;
            underflow   <= underflow | uf_c;
        end
    end

endmodule

// File: tb/tb_vga_disp_ctrl.sv
// Randomized bench for vga_disp_ctrl on a shrunken raster, checked against a per-pixel reference model.
module tb_vga_disp_ctrl;

    localparam int H_SYNC = 3, H_BP = 4, H_ACT = 16, H_FP = 2;
    localparam int V_SYNC = 2, V_BP = 2, V_ACT = 8, V_FP = 1;
    localparam int IMG_X0 = 4, IMG_Y0 = 2, IMG_W = 8, IMG_H = 4;
    localparam int RD_LAT = 1;
    localparam int HT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int VT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int FRAME = HT * VT;
    localparam logic [15:0] BG = 16'h0841;
    localparam logic [15:0] UF = 16'hF800;

    logic        clk_65m = 1'b0;
    logic        rst_n = 1'b1;
    logic        disp_en = 1'b0;
    logic        colorbar_sel = 1'b0;
    logic        vga_rd_req;
    logic [15:0] vga_din = '0;
    logic        vga_din_vld = 1'b0;
    logic        vga_hsync, vga_vsync, vga_de, frame_start, underflow;
    logic [15:0] vga_rgb;

    vga_disp_ctrl #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .RD_LAT(RD_LAT), .BG_COLOR(BG), .UF_COLOR(UF)
    ) dut (
        .clk_65m(clk_65m), .rst_n(rst_n), .disp_en(disp_en), .colorbar_sel(colorbar_sel),
        .vga_rd_req(vga_rd_req), .vga_din(vga_din), .vga_din_vld(vga_din_vld),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de), .vga_rgb(vga_rgb),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk_65m = ~clk_65m;

    typedef struct {
        bit          hs, vs, de, win, act, fs, req, vld;
        int          wx;
        logic [15:0] data;
    } rec_t;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    rec_t hist [8];
    int   k, n_chk, n_err, req_seen, exp_frame_reqs, salt, drop_lo, drop_hi;
    bit   m_act, m_uf, drop_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // Stage-0 view of raster position kk, straight from the timing arithmetic
    function automatic rec_t calc_rec(input int kk);
        rec_t r;
        int p, h, v, x, y, wy, idx;
        p = kk % FRAME; h = p % HT; v = p / HT;
        x = h - (H_SYNC + H_BP); y = v - (V_SYNC + V_BP);
        r.hs  = (h < H_SYNC);
        r.vs  = (v < V_SYNC);
        r.de  = (x >= 0) && (x < H_ACT) && (y >= 0) && (y < V_ACT);
        r.wx  = x - IMG_X0;
        wy    = y - IMG_Y0;
        r.win = r.de && (r.wx >= 0) && (r.wx < IMG_W) && (wy >= 0) && (wy < IMG_H);
        r.act = m_act;
        r.fs  = (p == 0);
        r.req = r.act && r.win;
        if (r.req) begin
            idx    = r.wx + wy * IMG_W;
            r.data = 16'(idx + salt);
            r.vld  = !(drop_en && idx >= drop_lo && idx <= drop_hi);
        end else begin
            r.data = 16'($urandom);
            r.vld  = 1'($urandom);
        end
        return r;
    endfunction

    task automatic tick();
        rec_t        r, o;
        logic [15:0] e_rgb;
        bit          e_hs, e_vs, e_de, e_fs;
`ifdef VGA_COLORBAR_EN
        logic        cb;
`endif
        @(posedge clk_65m);
        if (k % FRAME == FRAME - 1) m_act = disp_en;
`ifdef VGA_COLORBAR_EN
        cb = colorbar_sel;
`endif
        k++;
        r = calc_rec(k);
        hist[k % 8] = r;
        if (r.fs) begin
            check("reqs_per_frame", req_seen, exp_frame_reqs);
            req_seen = 0;
            exp_frame_reqs = m_act ? IMG_W * IMG_H : 0;
        end
        #1;
        if (k >= RD_LAT) begin
            vga_din     = hist[(k - RD_LAT) % 8].data;
            vga_din_vld = hist[(k - RD_LAT) % 8].vld;
        end
        @(negedge clk_65m);
        check("rd_req", vga_rd_req, r.req);
        if (vga_rd_req) req_seen++;
        e_hs = 1; e_vs = 1; e_de = 0; e_fs = 0; e_rgb = '0;
        if (k > RD_LAT) begin
            o = hist[(k - RD_LAT - 1) % 8];
            e_hs = !o.hs; e_vs = !o.vs; e_de = o.de; e_fs = o.fs;
            if (!o.de) e_rgb = '0;
            else if (!o.win || !o.act) e_rgb = BG;
`ifdef VGA_COLORBAR_EN
            else if (cb) e_rgb = bars[o.wx / (IMG_W / 8)];
`endif
            else if (o.vld) e_rgb = o.data;
            else begin e_rgb = UF; m_uf = 1; end
        end
        check("hsync", vga_hsync, e_hs);
        check("vsync", vga_vsync, e_vs);
        check("de", vga_de, e_de);
        check("frame_start", frame_start, e_fs);
        check("rgb", vga_rgb, e_rgb);
        check("underflow", underflow, m_uf);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int pos);
        tick();
        while (k % FRAME != pos) tick();
    endtask

    // Async reset: outputs must drop to reset values before any clock edge
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_hsync", vga_hsync, 1'b1);
        check("rst_vsync", vga_vsync, 1'b1);
        check("rst_de", vga_de, 1'b0);
        check("rst_rgb", vga_rgb, 16'h0000);
        check("rst_rd_req", vga_rd_req, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_underflow", underflow, 1'b0);
        vga_din_vld = 1'b0;
        @(posedge clk_65m);
        @(negedge clk_65m);
        rst_n = 1'b1;
        k = 0; m_act = 0; m_uf = 0; req_seen = 0; exp_frame_reqs = 0;
        hist[0] = calc_rec(0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; salt = 0; drop_en = 0; drop_lo = 0; drop_hi = -1;
        do_reset();
        run(FRAME + FRAME / 2);                      // idle: timing only, background window
        disp_en = 1'b1;                              // enable mid-frame
        run(3 * FRAME);
        run_to(0);
        drop_en = 1; drop_lo = 5; drop_hi = 7;       // three missing pixels
        run(FRAME - 1);
        drop_en = 0;
        run(FRAME);
        check("uf_sticky", underflow, 1'b1);
        run_to((V_SYNC + V_BP + IMG_Y0 + 1) * HT + 5);
        disp_en = 1'b0;                              // deassert mid-window
        run(2 * FRAME);
        for (int f = 0; f < 6; f++) begin
            run($urandom_range(FRAME - 1, 1));
            disp_en      = 1'($urandom);
            colorbar_sel = 1'($urandom);
            salt         = $urandom_range(0, 4000);
            drop_en      = ($urandom_range(0, 3) == 0);
            drop_lo      = $urandom_range(0, IMG_W * IMG_H - 1);
            drop_hi      = drop_lo + $urandom_range(0, 2);
        end
        run($urandom_range(FRAME - 1, 1));
        do_reset();                                  // reset mid-frame
        disp_en = 1'b1; colorbar_sel = 1'b0; drop_en = 0;
        run(2 * FRAME);
        colorbar_sel = 1'b1;
        run(FRAME + 3);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_disp_ctrl.md
Name: vga_disp_ctrl

Overview:
- Display-timing and pixel-fetch stage at 1024x768@60 in the clk_65m domain.
- Generates VGA sync and data-enable.
- Issues one read request per visible image pixel to the frame-buffer read side (vga_rd_req), which returns RGB565 pixels from its read FIFO.
- Places the image inside a configurable window; outside the window it drives the background colour.

Parameters:
- H_ACT, 1024: active pixels per line
- H_FP, 24: horizontal front porch
- H_SYNC, 136: hsync width
- H_BP, 160: horizontal back porch
- V_ACT, 768: active lines
- V_FP, 3: vertical front porch
- V_SYNC, 6: vsync width
- V_BP, 29: vertical back porch
- IMG_X0, 192: window left edge, in active-region coordinates
- IMG_Y0, 144: window top edge
- IMG_W, 640: window width
- IMG_H, 480: window height
- RD_LAT, 1: cycles from vga_rd_req to vga_din/vga_din_vld
- BG_COLOR, 16'h0000: colour outside the window
- UF_COLOR, 16'hF800: colour driven on underflow

Ports:
- clk_65m  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- disp_en  in  1  display enable
- colorbar_sel  in  1  test-pattern select (used only with the macro)
- vga_rd_req  out  1  pixel read request
- vga_din  in  16  RGB565 pixel
- vga_din_vld  in  1  pixel valid
- vga_hsync  out  1  hsync, active low
- vga_vsync  out  1  vsync, active low
- vga_de  out  1  active-region enable
- vga_rgb  out  16  RGB565 output
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- underflow  out  1  sticky underflow flag

Behaviour:
- Clock and reset: one clock, clk_65m. rst_n is asynchronous, active-low.
- Reset values: vga_hsync=1, vga_vsync=1, vga_de=0, vga_rgb=0, vga_rd_req=0, frame_start=0, underflow=0. Internal state: h_cnt=0, v_cnt=0, state=S_WAIT.
- Counter h_cnt, 11 bits:
  - Counts 0..H_TOTAL-1, then wraps to 0. H_TOTAL = H_SYNC+H_BP+H_ACT+H_FP = 1344.
  - Line order: sync, back porch, active, front porch.
- Counter v_cnt, 10 bits:
  - Increments when h_cnt wraps; range 0..V_TOTAL-1 (806), then wraps to 0.
  - H_TOTAL must be ≤ 2048 and V_TOTAL ≤ 1024.
- Stage-0 decode (combinational from the counters):
  - hs0 = h_cnt < H_SYNC
  - vs0 = v_cnt < V_SYNC
  - de0 = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1]
  - x = h_cnt-(H_SYNC+H_BP); y = v_cnt-(V_SYNC+V_BP)
  - win0 = de0 and x in [IMG_X0, IMG_X0+IMG_W-1] and y in [IMG_Y0, IMG_Y0+IMG_H-1]
- State machine:
  - S_WAIT: vga_rd_req=0. Move to S_ACTIVE when disp_en=1 and h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, so fetching always starts on frame pixel 0.
  - S_ACTIVE: vga_rd_req = win0 (combinational from registered state and counters, asserted in the stage-0 cycle). Move to S_WAIT at the same last-pixel-of-frame point if disp_en=0.
  - disp_en is sampled only at the frame boundary. Deasserting it mid-frame completes the current frame with exactly IMG_W*IMG_H requests.
- Alignment pipeline:
  - hs0/vs0/de0/win0 and an "active" bit are delayed RD_LAT cycles.
  - The delayed outputs are then registered once more, so output latency from the counters is RD_LAT+1.
  - vga_din is consumed in the same cycle its delayed win bit is high.
- Output pixel select, priority order:
  1. not de: 0
  2. not win, or state inactive: BG_COLOR
  3. vga_din_vld=1: vga_din
  4. otherwise: UF_COLOR, and underflow <= 1
- underflow is cleared only by reset.
- frame_start pulses with the registered output at the output-stage position of h_cnt=0, v_cnt=0.
- Reset mid-frame: all outputs return to their reset values immediately; counters restart from 0.

Optional Feature:
- Macro: VGA_COLORBAR_EN.
- Defined: when colorbar_sel=1, the in-window pixel is replaced by 8 vertical bars of equal width IMG_W/8. Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black. vga_rd_req still issues, and vga_din is discarded; underflow is not set.
- Undefined: colorbar_sel is ignored and no pattern logic is synthesised.

Decomposition:
- Shared param package:
  - 1024x768 timing constants
  - RGB565 colour constants
  - state encodings S_WAIT/S_ACTIVE
- Sub-module vga_timing_gen: h_cnt/v_cnt, stage-0 decode, frame-end strobe.
- Top level: state machine, delay pipeline, pixel mux, underflow logic.

Test Plan:
- Reset released with disp_en=0 -> hsync low for 136 clocks every 1344; vsync low for 6 lines every 806; vga_de high 1024 clocks per line on 768 lines; vga_rd_req never high; in-window rgb = BG_COLOR.
- disp_en=1 mid-frame -> no requests until the next frame_start; then exactly 640 requests per line on 480 lines, 307200 per frame; first request at h_cnt=296+192=488, v_cnt=35+144=179.
- Model returns vga_din=x+y*IMG_W with vld one cycle after each request -> output pixel (192,144) of the active region = 0; every window pixel matches the model; underflow stays 0.
- Model drops vld for 3 pixels -> those 3 pixels = 16'hF800; underflow=1 and stays 1 through later frames.
- disp_en deasserted at line 300 of the frame -> remaining frame requests still total 307200; zero requests in the next frame.
- VGA_COLORBAR_EN defined, colorbar_sel=1 -> window x=0..79 = 16'hFFFF, x=80..159 = 16'hFFE0, x=560..639 = 16'h0000.
